// File: rtl/spi_target.sv
// SPI mode-0 target: receives a SIZE-bit frame MSB-first and returns a SIZE-bit reply word.
// Latency: pin edge to internal event is SYNC_STAGES+1 clk_in cycles; r_valid_out follows CS_n rise by that amount.
// Backpressure: none; the initiator paces the frame, and a frame is strobed out with a one-cycle valid/error pulse.
//
// Ports: clk_in/reset_in (async, active-high); sck_in, cs_n_in, mosi_in SPI pins (oversampled);
//        data_in reply word captured at CS fall; r_miso_out/r_miso_oe_out MISO data and drive enable;
//        r_data_out last good frame; r_valid_out/r_error_out one-cycle strobes; r_busy_out frame in progress.
module spi_target #(
   parameter int SIZE        = 40,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk_in,
   input  logic            reset_in,
   input  logic            sck_in,
   input  logic            cs_n_in,
   input  logic            mosi_in,
   input  logic [SIZE-1:0] data_in,
   output logic            r_miso_out,
   output logic            r_miso_oe_out,
   output logic [SIZE-1:0] r_data_out,
   output logic            r_valid_out,
   output logic            r_error_out,
   output logic            r_busy_out
);

   localparam int              CW       = $clog2(SIZE + 2);
   localparam logic [CW-1:0]   CNT_SIZE = CW'(SIZE);
   localparam logic [CW-1:0]   CNT_MAX  = CW'(SIZE + 1);

   localparam logic [1:0] S_WAIT_IDLE = 2'd0;
   localparam logic [1:0] S_IDLE      = 2'd1;
   localparam logic [1:0] S_ACTIVE    = 2'd2;

   logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
   logic                   sck_dly_q, cs_dly_q;
   logic                   primed_q;
   logic [1:0]             state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [SIZE-1:0]        rx_q, rx_d;
   logic [SIZE-1:0]        tx_q, tx_d;
   logic [SIZE-1:0]        data_q, data_d;
   logic                   miso_q, miso_d;
   logic                   oe_q, oe_d;
   logic                   busy_q, busy_d;
   logic                   valid_q, valid_d;
   logic                   error_q, error_d;

   logic sck_s, cs_s, mosi_s;
   logic sck_rise, sck_fall, cs_rise, cs_fall;

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign cs_s     = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_dly_q;
   assign sck_fall = ~sck_s & sck_dly_q;
   assign cs_rise  = cs_s & ~cs_dly_q;
   assign cs_fall  = ~cs_s & cs_dly_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rx_d    = rx_q;
      tx_d    = tx_q;
      data_d  = data_q;
      miso_d  = miso_q;
      oe_d    = oe_q;
      busy_d  = busy_q;
      valid_d = 1'b0;
      error_d = 1'b0;
      case (state_q)
         S_WAIT_IDLE: begin
            // The CS synchroniser resets to 1, so its reset value alone proves nothing.
            // Leave only once the whole pipeline has been refilled from the pin and reads
            // high; a reset released mid-frame then waits out the rest of that frame.
            if (primed_q && (&cs_sync_q) && cs_dly_q) begin
               state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            if (cs_fall) begin
               tx_d    = data_in;
               cnt_d   = '0;
               miso_d  = data_in[SIZE-1];
               oe_d    = 1'b1;
               busy_d  = 1'b1;
               state_d = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (sck_rise) begin
               rx_d = {rx_q[SIZE-2:0], mosi_s};
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            // The first bit is already on MISO from CS fall; shift only after a rising edge.
            if (sck_fall && (cnt_q != '0)) begin
               tx_d   = {tx_q[SIZE-2:0], 1'b0};
               miso_d = tx_q[SIZE-2];
            end
            // Evaluated after the SCK action so a same-cycle last edge still counts.
            if (cs_rise) begin
               oe_d    = 1'b0;
               busy_d  = 1'b0;
               state_d = S_IDLE;
               if (cnt_d == CNT_SIZE) begin
                  data_d  = rx_d;
                  valid_d = 1'b1;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         default: state_d = S_WAIT_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         sck_sync_q  <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sck_dly_q   <= 1'b0;
         cs_dly_q    <= 1'b1;
         primed_q    <= 1'b0;
         state_q     <= S_WAIT_IDLE;
         cnt_q       <= '0;
         rx_q        <= '0;
         tx_q        <= '0;
         data_q      <= '0;
         miso_q      <= 1'b0;
         oe_q        <= 1'b0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_in};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_in};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
         sck_dly_q   <= sck_s;
         cs_dly_q    <= cs_s;
         primed_q    <= 1'b1;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         data_q      <= data_d;
         miso_q      <= miso_d;
         oe_q        <= oe_d;
         busy_q      <= busy_d;
         valid_q     <= valid_d;
         error_q     <= error_d;
      end
   end

   assign r_miso_out    = miso_q;
   assign r_miso_oe_out = oe_q;
   assign r_data_out    = data_q;
   assign r_valid_out   = valid_q;
   assign r_error_out   = error_q;
   assign r_busy_out    = busy_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target acting as SPI initiator with SCK = clk/8.
// Expected frames are queued when driven and checked when the target pulses valid or error.
// Unexpected pulses, wrong pulse kind or wrong data are reported as failures.
module tb_spi_target;

   logic        clk = 1'b0;
   logic        reset_in = 1'b1;
   logic        sck = 1'b0;
   logic        cs_n = 1'b1;
   logic        mosi = 1'b0;
   logic [39:0] data_in = '0;
   logic        miso, miso_oe, r_valid, r_error, r_busy;
   logic [39:0] r_data;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic        err;
      logic [39:0] d;
   } exp_t;
   exp_t sbq[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   spi_target #(.SIZE(40), .SYNC_STAGES(2)) dut (
      .clk_in        (clk),
      .reset_in      (reset_in),
      .sck_in        (sck),
      .cs_n_in       (cs_n),
      .mosi_in       (mosi),
      .data_in       (data_in),
      .r_miso_out    (miso),
      .r_miso_oe_out (miso_oe),
      .r_data_out    (r_data),
      .r_valid_out   (r_valid),
      .r_error_out   (r_error),
      .r_busy_out    (r_busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer: every strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!reset_in && (r_valid || r_error)) begin
         if (sbq.size() == 0) begin
            chk("unexpected_pulse", 64'({r_valid, r_error}), 64'd0);
         end else begin
            mon_e = sbq.pop_front();
            chk("pulse_kind", 64'({r_valid, r_error}), mon_e.err ? 64'd1 : 64'd2);
            chk("rx_data", 64'(r_data), 64'(mon_e.d));
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cs_fall_t();
      cs_n = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   // Clock n bits: MOSI set half a period before each rising edge, MISO sampled at the rising edge.
   task automatic shift_bits(input logic [39:0] w, input int n, output logic [39:0] mi);
      logic [39:0] t;
      t  = w;
      mi = '0;
      for (int i = 0; i < n; i++) begin
         mosi = t[39];
         t    = {t[38:0], 1'b0};
         repeat (4) @(negedge clk);
         mi   = {mi[38:0], miso};
         sck  = 1'b1;
         repeat (4) @(negedge clk);
         sck  = 1'b0;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic frame(input logic [39:0] mw, input logic [39:0] din, input int n,
                        output logic [39:0] mi);
      data_in = din;
      cs_fall_t();
      shift_bits(mw, n, mi);
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   initial begin
      logic [39:0] mi, mi2, last_good, w1, w2;
      int n;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_outputs", 64'({miso, miso_oe, r_data, r_valid, r_error, r_busy}), 64'd0);
      reset_in = 1'b0;
      repeat (6) @(negedge clk);
      chk("idle_oe", 64'(miso_oe), 64'd0);

      // 1: full frame, valid latency after CS rise
      data_in = 40'h3C_DEAD_BEEF;
      sbq.push_back({1'b0, 40'hA5_1234_5678});
      cs_fall_t();
      chk("busy_in_frame", 64'({r_busy, miso_oe}), 64'd3);
      shift_bits(40'hA5_1234_5678, 40, mi);
      cs_n = 1'b1;
      n = 0;
      while (!r_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("valid_latency", 64'((n >= 3) && (n <= 4)), 64'd1);
      repeat (8) @(negedge clk);
      chk("miso_frame1", 64'(mi), 64'h3C_DEAD_BEEF);
      chk("data_hold1", 64'(r_data), 64'hA5_1234_5678);
      chk("idle_after1", 64'({r_busy, miso_oe}), 64'd0);
      last_good = 40'hA5_1234_5678;

      // 2: short and long frames give errors, data held
      sbq.push_back({1'b1, last_good});
      frame(40'h11_2233_4455, 40'h0, 39, mi);
      sbq.push_back({1'b1, last_good});
      frame(40'h66_7788_99AA, 40'h0, 41, mi);
      chk("data_after_errs", 64'(r_data), 64'(last_good));

      // 3: back-to-back frames, data_in changed mid-frame
      sbq.push_back({1'b0, 40'h00_0000_0001});
      data_in = 40'h12_3456_789A;
      cs_fall_t();
      shift_bits(40'h00_0000_0001, 20, mi);
      data_in = 40'hCA_FEF0_0D55;
      shift_bits(40'h00_0000_0001 << 20, 20, mi2);
      mi = (mi << 20) | mi2;
      cs_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("miso_b2b1", 64'(mi), 64'h12_3456_789A);
      sbq.push_back({1'b0, 40'hFF_FFFF_FFFF});
      cs_fall_t();
      shift_bits(40'hFF_FFFF_FFFF, 40, mi);
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("miso_b2b2", 64'(mi), 64'hCA_FEF0_0D55);
      chk("data_b2b2", 64'(r_data), 64'hFF_FFFF_FFFF);
      chk("sb_drained3", 64'(sbq.size()), 64'd0);

      // 4: reset mid-frame, release while CS low
      data_in = 40'h55_AA55_AA55;
      cs_fall_t();
      shift_bits(40'h0F_0F0F_0F0F, 20, mi);
      reset_in = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_midframe", 64'({miso, miso_oe, r_data, r_valid, r_error, r_busy}), 64'd0);
      reset_in = 1'b0;
      shift_bits(40'h0F_0F0F_0F0F << 20, 20, mi);
      chk("no_busy_after_reset", 64'({r_busy, miso_oe}), 64'd0);
      cs_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("data_zero_after_reset", 64'(r_data), 64'd0);
      sbq.push_back({1'b0, 40'h96_C3A5_0F17});
      frame(40'h96_C3A5_0F17, 40'h81_4242_1818, 40, mi);
      chk("miso_after_reset", 64'(mi), 64'h81_4242_1818);

      // 5: SCK toggling while CS high
      for (int i = 0; i < 10; i++) begin
         sck = ~sck;
         mosi = ~mosi;
         repeat (4) @(negedge clk);
         chk("cs_high_idle", 64'({r_busy, miso_oe}), 64'd0);
      end
      sck = 1'b0;
      repeat (8) @(negedge clk);
      chk("cs_high_data", 64'(r_data), 64'h96_C3A5_0F17);

      // 6: loopback with random words
      for (int k = 0; k < 3; k++) begin
         w1 = 40'({$urandom, $urandom});
         w2 = 40'({$urandom, $urandom});
         sbq.push_back({1'b0, w1});
         frame(w1, w2, 40, mi);
         chk("loop_miso", 64'(mi), 64'(w2));
         chk("loop_data", 64'(r_data), 64'(w1));
      end

      chk("sb_empty", 64'(sbq.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI mode-0 target (responder) that terminates a SIZE-bit frame from an SPI initiator such as the board's `spi` master.
- It lets a second FPGA, or a bench model of a stepper driver, receive the 40-bit driver datagrams and return a 40-bit reply.
- It oversamples SCK, CS_n and MOSI on its own clock, shifts MSB-first, and hands a complete frame to local logic with a one-cycle valid strobe.

Parameters:
- SIZE, 40, frame length in bits for both RX and TX.
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers (≥2).

Ports:
- clk_in  input  1  system clock; all state on rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- sck_in  input  1  SPI clock from initiator; idle low.
- cs_n_in  input  1  chip select, active low.
- mosi_in  input  1  initiator-to-target data.
- data_in  input  SIZE  reply word; captured at frame start.
- r_miso_out  output  1  target-to-initiator data.
- r_miso_oe_out  output  1  MISO drive enable; top level tristates MISO when low.
- r_data_out  output  SIZE  last complete received frame.
- r_valid_out  output  1  one-cycle pulse: r_data_out updated.
- r_error_out  output  1  one-cycle pulse: frame ended with bit count ≠ SIZE.
- r_busy_out  output  1  high while a frame is in progress.

Behaviour:
- Reset values (asynchronous, while reset_in high): all outputs 0; shift registers 0; bit counter 0; synchronisers 0 except CS synchroniser, which resets to 1; FSM enters WAIT_IDLE.
- Synchronisation:
  - sck_in, cs_n_in and mosi_in each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last synchroniser stage with one extra delay flop.
  - Latency from pin edge to internal event is SYNC_STAGES+1 clk_in cycles.
- SCK limit: high and low phases must each last ≥ SYNC_STAGES+2 clk_in cycles. Faster SCK is unsupported and not detected.
- FSM states:
  - WAIT_IDLE: ignore everything until CS_n sync = 1, then go to IDLE. This prevents a reset released mid-frame from producing a partial frame.
  - IDLE: on CS_n sync falling edge:
    - tx_shift <= data_in; counter <= 0.
    - r_miso_out <= data_in[SIZE-1]; r_miso_oe_out <= 1; r_busy_out <= 1.
    - Go to ACTIVE.
  - ACTIVE:
    - SCK sync rising edge: rx_shift <= {rx_shift[SIZE-2:0], mosi_sync}; counter increments, saturating at SIZE+1.
    - SCK sync falling edge: tx_shift shifts left with 0 fill, and r_miso_out <= new tx_shift MSB. Ignored when counter = 0.
    - CS_n sync rising edge:
      - r_miso_oe_out <= 0; r_busy_out <= 0; go to IDLE.
      - If counter == SIZE, then in the same cycle r_data_out <= rx_shift (including any bit shifted that cycle) and r_valid_out <= 1.
      - Otherwise r_error_out <= 1 and r_data_out is unchanged.
- Strobes: r_valid_out and r_error_out are high for exactly one clk_in cycle and are never high simultaneously.
- Simultaneous SCK and CS events in one cycle: the SCK action is applied first, then the CS-rise evaluation uses the updated counter.
- SCK edges while not in ACTIVE are ignored. mosi_in is sampled only on SCK rising edges.
- data_in is sampled only at frame start. Changes mid-frame do not affect the current reply.
- r_data_out holds its value until the next valid frame.
- Back-to-back frames: a new CS fall is accepted one cycle after returning to IDLE.

Test Plan:
1. Reset, then a 40-bit frame: MOSI 0xA5_1234_5678 with data_in = 0x3C_DEAD_BEEF, SCK = clk/8. Required: MISO bits read by the initiator = 0x3CDEADBEEF; r_data_out = 0xA512345678; r_valid_out high for 1 cycle, SYNC_STAGES+1..SYNC_STAGES+2 cycles after CS rises; r_error_out stays 0.
2. Short frame of 39 clocks, then long frame of 41 clocks. Required: each gives one r_error_out pulse, r_data_out keeps its previous value, r_valid_out stays 0.
3. Two back-to-back frames: 0x0000000001, then 0xFFFFFFFFFF, with data_in changed mid-frame. Required: two valid pulses and r_data_out updates in order; the second reply equals the data_in value present at the second CS fall.
4. Reset asserted after 20 bits, released while CS is still low, remaining 20 bits clocked, then CS rises. Required: outputs all 0 during reset; no r_valid_out or r_error_out pulse; the next full frame is received correctly.
5. SCK toggling while CS high. Required: no state change, r_miso_oe_out = 0, r_busy_out = 0.
6. Loopback with the `spi` master (SIZE 40, clk_count_max 4) through the top-level pins. Required: the master's data_out equals the target's data_in, and the target's r_data_out equals the master's data_in.
